exec_monitor: RTL and testbench



---
 rtl/exec_monitor.sv | 164 ++++++++++++++++
 tb/tb_exec_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_monitor.sv
// exec_monitor: observer for the FCFS task scheduler.
// Samples task_out/empty each cycle while monitoring. Consecutive cycles with
// the same task ID are merged into one execution segment. Each closed segment
// is pushed as {id, start cycle, run length} into a small record FIFO, which is
// read out through a valid/ready handshake. Busy and idle cycle counts are kept
// for throughput and utilisation checks.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   st           start pulse (same pulse that starts the scheduler)
//   empty        scheduler empty flag
//   task_out     scheduled task ID this cycle, or IDLE_ID
//   rec_valid    record available at FIFO head
//   rec_ready    consumer accepts the head record
//   rec_id       head record task ID
//   rec_start    head record first-cycle index
//   rec_len      head record length in cycles (saturating)
//   overflow     sticky: a record was dropped because the FIFO was full
//   busy_cnt     monitored cycles with a task scheduled (saturating)
//   idle_cnt     monitored cycles with no task scheduled (saturating)
//   drained      monitoring, scheduler empty, no open segment, FIFO empty
module exec_monitor #(
  parameter int unsigned TW      = 16,
  parameter int unsigned LW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] IDLE_ID = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          empty,
  input  logic [15:0]   task_out,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [15:0]   rec_id,
  output logic [TW-1:0] rec_start,
  output logic [LW-1:0] rec_len,
  output logic          overflow,
  output logic [TW-1:0] busy_cnt,
  output logic [TW-1:0] idle_cnt,
  output logic          drained
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_INIT, S_MON} state_t;

  state_t        state;
  logic [TW-1:0] cyc;

  // Open segment
  logic          cur_valid;
  logic [15:0]   cur_id;
  logic [TW-1:0] cur_start;
  logic [LW-1:0] cur_len;

  // Record FIFO storage
  logic [15:0]   mem_id    [DEPTH];
  logic [TW-1:0] mem_start [DEPTH];
  logic [LW-1:0] mem_len   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic mon;
  logic is_idle;
  logic same_id;
  logic seg_close;
  logic seg_open;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;

  always_comb begin
    mon        = (state == S_MON);
    is_idle    = (task_out == IDLE_ID);
    same_id    = cur_valid && (task_out == cur_id);
    seg_close  = mon && cur_valid && !same_id;
    seg_open   = mon && !is_idle && !same_id;
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pop        = !fifo_empty && rec_ready;
    // A same-cycle pop frees the slot a push into a full FIFO needs.
    push       = seg_close && (!fifo_full || pop);
  end

  always_comb begin
    rec_valid = !fifo_empty;
    rec_id    = '0;
    rec_start = '0;
    rec_len   = '0;
    // Head is gated so stale storage is never visible while the FIFO is empty.
    if (!fifo_empty) begin
      rec_id    = mem_id[rd_ptr];
      rec_start = mem_start[rd_ptr];
      rec_len   = mem_len[rd_ptr];
    end
    drained = mon && empty && !cur_valid && fifo_empty;
  end

  // Control, counters, segment tracking and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cyc       <= '0;
      busy_cnt  <= '0;
      idle_cnt  <= '0;
      overflow  <= 1'b0;
      cur_valid <= 1'b0;
      cur_id    <= '0;
      cur_start <= '0;
      cur_len   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_INIT: if (st) state <= S_MON;
        S_MON: begin
          cyc <= cyc + TW'(1);
          if (is_idle) begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + TW'(1);
          end else begin
            if (busy_cnt != '1) busy_cnt <= busy_cnt + TW'(1);
          end

          if (is_idle) begin
            cur_valid <= 1'b0;
          end else if (seg_open) begin
            cur_valid <= 1'b1;
            cur_id    <= task_out;
            cur_start <= cyc;
            cur_len   <= LW'(1);
          end else if (cur_len != '1) begin
            cur_len <= cur_len + LW'(1);
          end

          if (seg_close && !push) overflow <= 1'b1;
        end
        default: state <= S_INIT;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_id[wr_ptr]    <= cur_id;
      mem_start[wr_ptr] <= cur_start;
      mem_len[wr_ptr]   <= cur_len;
    end
  end

endmodule

// File: tb/tb_exec_monitor.sv
module tb_exec_monitor;

  localparam logic [15:0] IDLE = 16'hFFFF;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  logic        empty = 1'b0;
  logic [15:0] task_out = 16'hFFFF;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [15:0] rec_id;
  logic [15:0] rec_start;
  logic [7:0]  rec_len;
  logic        overflow;
  logic [15:0] busy_cnt;
  logic [15:0] idle_cnt;
  logic        drained;

  int n_checks = 0;
  int n_errors = 0;

  exec_monitor #(.TW(16), .LW(8), .DEPTH(DEPTH), .IDLE_ID(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .st(st), .empty(empty), .task_out(task_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start(rec_start), .rec_len(rec_len), .overflow(overflow),
    .busy_cnt(busy_cnt), .idle_cnt(idle_cnt), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // Segments are found as maximal runs of one non-idle ID; the run is counted
  // without bound and clipped to 255 only when reported.
  typedef struct { logic [15:0] id; int start; int len; } rec_t;
  rec_t q[$];
  bit          m_mon, m_run, m_ovf;
  logic [15:0] m_run_id;
  int          m_run_start, m_run_len, m_cyc, m_busy, m_idle;

  task automatic model_update();
    bit   have;
    rec_t r;
    if (rst) begin
      m_mon = 0; m_run = 0; m_ovf = 0; m_cyc = 0; m_busy = 0; m_idle = 0;
      q.delete();
    end else if (!m_mon) begin
      if (st) m_mon = 1;
    end else begin
      bit popped;
      popped = (q.size() > 0) && rec_ready;
      have = 0;
      if (m_run && task_out != m_run_id) begin
        have = 1;
        r.id = m_run_id; r.start = m_run_start;
        r.len = (m_run_len > 255) ? 255 : m_run_len;
      end
      if (task_out == IDLE) m_run = 0;
      else if (m_run && task_out == m_run_id) m_run_len++;
      else begin
        m_run = 1; m_run_id = task_out; m_run_start = m_cyc; m_run_len = 1;
      end
      if (popped) void'(q.pop_front());
      if (have) begin
        if (q.size() < DEPTH) q.push_back(r);
        else m_ovf = 1;
      end
      if (task_out == IDLE) m_idle = (m_idle < 65535) ? m_idle + 1 : 65535;
      else                  m_busy = (m_busy < 65535) ? m_busy + 1 : 65535;
      m_cyc = (m_cyc + 1) % 65536;
    end
  endtask

  task automatic model_check();
    chk("m_rec_valid", 32'(rec_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_rec_id", 32'(rec_id), 32'(q[0].id));
      chk("m_rec_start", 32'(rec_start), 32'(q[0].start));
      chk("m_rec_len", 32'(rec_len), 32'(q[0].len));
    end
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_busy_cnt", 32'(busy_cnt), 32'(m_busy));
    chk("m_idle_cnt", 32'(idle_cnt), 32'(m_idle));
    chk("m_drained", 32'(drained), 32'(m_mon && empty && !m_run && q.size() == 0));
  endtask

  // Drive one cycle's inputs, then sample outputs at the negedge.
  task automatic begin_cycle(input logic r, input logic s, input logic e,
                             input logic [15:0] t, input logic rd);
    rst = r; st = s; empty = e; task_out = t; rec_ready = rd;
    @(negedge clk);
    model_check();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic r, input logic s, input logic e,
                      input logic [15:0] t, input logic rd);
    begin_cycle(r, s, e, t, rd);
    end_cycle();
  endtask

  // ---------------- Directed table ----------------
  typedef struct {
    logic r, s, e; logic [15:0] t; logic rd;
    logic x_valid; logic [15:0] x_id; logic [15:0] x_start; logic [7:0] x_len;
    logic [15:0] x_busy; logic x_drained;
  } vec_t;
  vec_t tbl[18];

  initial begin
    rec_t exp4[4];
    int ready_pct;
    logic [15:0] cur_t;

    tbl[0]  = '{1'b0,1'b1,1'b1,16'hFFFF,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,16'h0011,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,16'h0011,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd1,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,16'h0011,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd2,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,16'hFFFF,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd3,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,16'hFFFF,1'b1, 1'b1,16'h0011,16'd0,8'd3, 16'd3,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,16'hFFFF,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd3,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,16'hFFFF,1'b0, 1'b0,16'h0,16'd0,8'd0, 16'd3,1'b1};
    tbl[8]  = '{1'b0,1'b1,1'b1,16'hFFFF,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,16'h0011,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,16'h0011,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,16'h0022,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd2,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,16'h0022,1'b1, 1'b1,16'h0011,16'd0,8'd2, 16'd3,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,16'h0022,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd4,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,16'h0022,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd5,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd6,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b1, 1'b1,16'h0022,16'd2,8'd4, 16'd6,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b1, 1'b0,16'h0,16'd0,8'd0, 16'd6,1'b1};

    // Bring the DUT out of its unknown power-up state
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Test 1: reset, then idle in S_INIT
    step(1, 0, 1, IDLE, 0);
    step(1, 0, 1, IDLE, 0);
    for (int i = 0; i < 5; i++) begin
      begin_cycle(0, 0, 1, IDLE, 0);
      chk("init_valid", 32'(rec_valid), 32'd0);
      chk("init_busy", 32'(busy_cnt), 32'd0);
      chk("init_idle", 32'(idle_cnt), 32'd0);
      chk("init_drained", 32'(drained), 32'd0);
      end_cycle();
    end

    // Tests 2 and 3: single segment, then two back-to-back segments
    for (int i = 0; i < 18; i++) begin
      begin_cycle(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].t, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), 32'(rec_valid), 32'(tbl[i].x_valid));
      if (tbl[i].x_valid) begin
        chk($sformatf("tbl%0d_id", i), 32'(rec_id), 32'(tbl[i].x_id));
        chk($sformatf("tbl%0d_start", i), 32'(rec_start), 32'(tbl[i].x_start));
        chk($sformatf("tbl%0d_len", i), 32'(rec_len), 32'(tbl[i].x_len));
      end
      chk($sformatf("tbl%0d_busy", i), 32'(busy_cnt), 32'(tbl[i].x_busy));
      chk($sformatf("tbl%0d_drained", i), 32'(drained), 32'(tbl[i].x_drained));
      end_cycle();
    end

    // Test 4: five one-cycle segments into a 4-deep FIFO with no consumer
    step(1, 0, 0, IDLE, 0);
    step(0, 1, 0, IDLE, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, (i % 2 == 0) ? 16'h0001 : 16'h0002, 0);
    step(0, 0, 1, IDLE, 0);
    exp4[0] = '{16'h0001, 0, 1};
    exp4[1] = '{16'h0002, 1, 1};
    exp4[2] = '{16'h0001, 2, 1};
    exp4[3] = '{16'h0002, 3, 1};
    begin_cycle(0, 0, 1, IDLE, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    end_cycle();
    for (int i = 0; i < 4; i++) begin
      begin_cycle(0, 0, 1, IDLE, 1);
      chk($sformatf("drain%0d_valid", i), 32'(rec_valid), 32'd1);
      chk($sformatf("drain%0d_id", i), 32'(rec_id), 32'(exp4[i].id));
      chk($sformatf("drain%0d_start", i), 32'(rec_start), 32'(exp4[i].start));
      chk($sformatf("drain%0d_len", i), 32'(rec_len), 32'(exp4[i].len));
      end_cycle();
    end
    begin_cycle(0, 0, 1, IDLE, 1);
    chk("drain_done_valid", 32'(rec_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    end_cycle();

    // Test 5: long run saturates the length field
    step(1, 0, 0, IDLE, 0);
    step(0, 1, 0, IDLE, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 16'h0033, 0);
    step(0, 0, 1, IDLE, 0);
    begin_cycle(0, 0, 1, IDLE, 1);
    chk("sat_valid", 32'(rec_valid), 32'd1);
    chk("sat_id", 32'(rec_id), 32'h0033);
    chk("sat_start", 32'(rec_start), 32'd0);
    chk("sat_len", 32'(rec_len), 32'd255);
    chk("sat_busy", 32'(busy_cnt), 32'd300);
    end_cycle();

    // Test 6: reset mid-segment discards everything
    step(1, 0, 0, IDLE, 0);
    step(0, 1, 0, IDLE, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0044, 1);
    step(1, 0, 1, IDLE, 1);
    for (int i = 0; i < 3; i++) begin
      begin_cycle(0, 0, 1, IDLE, 1);
      chk("rstmid_valid", 32'(rec_valid), 32'd0);
      chk("rstmid_busy", 32'(busy_cnt), 32'd0);
      chk("rstmid_idle", 32'(idle_cnt), 32'd0);
      chk("rstmid_ovf", 32'(overflow), 32'd0);
      chk("rstmid_drained", 32'(drained), 32'd0);
      end_cycle();
    end

    // Randomized traffic against the reference model
    step(1, 0, 0, IDLE, 0);
    ready_pct = 50;
    cur_t = IDLE;
    for (int i = 0; i < 4000; i++) begin
      logic r, s, e, rd;
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 10;
          1: ready_pct = 50;
          default: ready_pct = 95;
        endcase
      end
      if ($urandom_range(0, 99) >= 60) begin
        case ($urandom_range(0, 3))
          0: cur_t = 16'h0001;
          1: cur_t = 16'h0002;
          2: cur_t = 16'h0003;
          default: cur_t = IDLE;
        endcase
      end
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 1) == 0);
      rd = ($urandom_range(0, 99) < ready_pct);
      step(r, s, e, cur_t, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
